// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter that owns the D/ClrN/PreN pins of a shared DFF register.
// Optional owner locking is enabled with `define SHREG_LOCK_EN.
module dff_reg_arbiter #(
  parameter int unsigned W    = 8,
  parameter int unsigned NREQ = 4
) (
  input  logic                CLK,
  input  logic                Clr,
  input  logic [NREQ-1:0]     req,
  input  logic [2*NREQ-1:0]   op,
  input  logic [W*NREQ-1:0]   data,
  input  logic [W*NREQ-1:0]   mask,
`ifdef SHREG_LOCK_EN
  input  logic [NREQ-1:0]     lock,
`endif
  input  logic [W-1:0]        reg_Q,
  output logic [W-1:0]        reg_D,
  output logic [W-1:0]        reg_ClrN,
  output logic [W-1:0]        reg_PreN,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     done,
  output logic                busy
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] OpLoad   = 2'b00;
  localparam logic [1:0] OpClear  = 2'b01;
  localparam logic [1:0] OpPreset = 2'b10;
  localparam logic [1:0] OpNop    = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StApply = 2'b01,
    StDone  = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [PtrW-1:0]   own_q, own_d;
  logic [1:0]        op_q, op_d;
  logic [W-1:0]      data_q, data_d;
  logic [W-1:0]      mask_q, mask_d;
  logic [W-1:0]      clrn_q, clrn_d;
  logic [W-1:0]      pren_q, pren_d;
  logic              locked_q, locked_d;

  logic              found;
  logic [PtrW-1:0]   sel;
  logic [2*NREQ-1:0] op_shift;
  logic [W*NREQ-1:0] data_shift;
  logic [W*NREQ-1:0] mask_shift;
  logic [1:0]        op_sel;
  logic [W-1:0]      data_sel;
  logic [W-1:0]      mask_sel;

  // First requester at or after the pointer, wrapping; a locked owner is the only candidate.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      automatic int              idx  = int'(ptr_q) + k;
      automatic logic [PtrW-1:0] cand;
      if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
      cand = PtrW'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    if (locked_q) begin
      found = req[own_q];
      sel   = own_q;
    end
  end

  always_comb begin
    op_shift   = op >> (2 * sel);
    data_shift = data >> (W * sel);
    mask_shift = mask >> (W * sel);
    op_sel     = op_shift[1:0];
    data_sel   = data_shift[W-1:0];
    mask_sel   = mask_shift[W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    own_d    = own_q;
    op_d     = op_q;
    data_d   = data_q;
    mask_d   = mask_q;
    clrn_d   = '1;
    pren_d   = '1;
    locked_d = locked_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StApply;
          own_d   = sel;
          op_d    = op_sel;
          data_d  = data_sel;
          mask_d  = mask_sel;
          // Pins are registered, so they must be set up on the edge entering APPLY.
          if (op_sel == OpClear)  clrn_d = ~mask_sel;
          if (op_sel == OpPreset) pren_d = ~mask_sel;
        end
      end
      StApply: begin
        state_d = StDone;
        if (!locked_q) begin
          if (own_q == PtrW'(NREQ - 1)) ptr_d = '0;
          else                          ptr_d = own_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
`ifdef SHREG_LOCK_EN
        locked_d = lock[own_q];
`else
        locked_d = 1'b0;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Clr) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      own_q    <= '0;
      op_q     <= OpNop;
      data_q   <= '0;
      mask_q   <= '0;
      clrn_q   <= '0;
      pren_q   <= '1;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      own_q    <= own_d;
      op_q     <= op_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      clrn_q   <= clrn_d;
      pren_q   <= pren_d;
      locked_q <= locked_d;
    end
  end

  always_comb begin
    reg_D = reg_Q;
    if (state_q == StApply) begin
      case (op_q)
        OpLoad:   reg_D = (data_q & mask_q) | (reg_Q & ~mask_q);
        OpClear:  reg_D = reg_Q & ~mask_q;
        OpPreset: reg_D = reg_Q | mask_q;
        default:  reg_D = reg_Q;
      endcase
    end
  end

  always_comb begin
    gnt  = '0;
    done = '0;
    if (state_q == StApply) gnt[own_q]  = 1'b1;
    if (state_q == StDone)  done[own_q] = 1'b1;
  end

  assign busy     = (state_q != StIdle);
  assign reg_ClrN = clrn_q;
  assign reg_PreN = pren_q;

endmodule
